// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the external memory cycle controller.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    RECOVER = 3'd3,
    DONE    = 3'd4
  } mem_state_e;

  localparam int unsigned ROM_WAIT_DEF = 1;
  localparam int unsigned RAM_WAIT_DEF = 3;
  localparam int unsigned WE_SETUP_DEF = 1;
  localparam int unsigned CNT_W_DEF    = 4;
  localparam int unsigned CYC_CNT_W    = 16;

  typedef struct packed {
    logic wait_n;
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic rd_latch;
  } mem_strobe_t;

  localparam mem_strobe_t STROBE_IDLE = '{wait_n: 1'b1, ce_n: 1'b1, oe_n: 1'b1,
                                          we_n: 1'b1, rd_latch: 1'b0};

  // An access window of zero clocks is meaningless; treat it as one.
  function automatic int unsigned clamp_wait(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/ext_mem_cycle_ctrl_wait_counter.sv
// Loadable down-counter timing the SETUP and ACCESS windows; tc_c flags count==1.
module wait_counter
  import mem_bus_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign tc_c = (count == CNT_W'(1));

endmodule

// File: rtl/ext_mem_cycle_ctrl.sv
// Sequences one external SRAM/ROM access per Z80 memory cycle and stalls the CPU via wait_n.
// Optional completed-access counter enabled by defining MEM_CYCLE_CNT_EN.
module ext_mem_cycle_ctrl
  import mem_bus_pkg::*;
#(
  parameter int unsigned ROM_WAIT = ROM_WAIT_DEF,
  parameter int unsigned RAM_WAIT = RAM_WAIT_DEF,
  parameter int unsigned WE_SETUP = WE_SETUP_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rom_cs,
  input  logic                 ram_cs,
  input  logic                 memread,
  input  logic                 memwrite,
  output logic                 wait_n,
  output logic                 mem_ce_n,
  output logic                 mem_oe_n,
  output logic                 mem_we_n,
  output logic                 rd_latch,
  output logic [CYC_CNT_W-1:0] cycle_cnt
);

  localparam logic [CNT_W-1:0] ROM_CNT   = CNT_W'(clamp_wait(ROM_WAIT));
  localparam logic [CNT_W-1:0] RAM_CNT   = CNT_W'(clamp_wait(RAM_WAIT));
  localparam logic [CNT_W-1:0] SETUP_CNT = CNT_W'(WE_SETUP);

  mem_state_e       state, state_d;
  mem_strobe_t      strb, strb_d;
  logic             is_wr, is_wr_d;
  logic             cnt_load, cnt_dec, tc_c;
  logic [CNT_W-1:0] cnt_val;
  logic             start_c;

  assign start_c = (rom_cs | ram_cs) & (memread | memwrite);

  wait_counter #(.CNT_W(CNT_W)) u_wait_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .tc_c     (tc_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      strb  <= STROBE_IDLE;
      is_wr <= 1'b0;
    end else begin
      state <= state_d;
      strb  <= strb_d;
      is_wr <= is_wr_d;
    end
  end

  // Next state plus strobes decoded from the state being entered, so they are registered.
  always_comb begin
    state_d  = state;
    strb_d   = STROBE_IDLE;
    is_wr_d  = is_wr;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;

    unique case (state)
      IDLE: begin
        if (start_c) begin
          is_wr_d = ram_cs & ~rom_cs & memwrite;
          if (rom_cs & memwrite & ~memread) begin
            state_d = DONE;
          end else if (is_wr_d && (WE_SETUP != 0)) begin
            state_d  = SETUP;
            cnt_load = 1'b1;
            cnt_val  = SETUP_CNT;
          end else begin
            state_d  = ACCESS;
            cnt_load = 1'b1;
            cnt_val  = rom_cs ? ROM_CNT : RAM_CNT;
          end
        end
      end
      SETUP: begin
        if (tc_c) begin
          state_d  = ACCESS;
          cnt_load = 1'b1;
          cnt_val  = RAM_CNT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ACCESS: begin
        if (tc_c) state_d = RECOVER;
        else      cnt_dec = 1'b1;
      end
      RECOVER: state_d = DONE;
      DONE: begin
        if (!(memread | memwrite)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      SETUP: begin
        strb_d.wait_n = 1'b0;
        strb_d.ce_n   = 1'b0;
      end
      ACCESS: begin
        strb_d.wait_n = 1'b0;
        strb_d.ce_n   = 1'b0;
        strb_d.oe_n   = is_wr_d;
        strb_d.we_n   = ~is_wr_d;
      end
      RECOVER: begin
        strb_d.ce_n     = 1'b0;
        strb_d.rd_latch = ~is_wr_d;
      end
      default: strb_d = STROBE_IDLE;
    endcase
  end

  assign wait_n   = strb.wait_n;
  assign mem_ce_n = strb.ce_n;
  assign mem_oe_n = strb.oe_n;
  assign mem_we_n = strb.we_n;
  assign rd_latch = strb.rd_latch;

`ifdef MEM_CYCLE_CNT_EN
  logic [CYC_CNT_W-1:0] cyc_q;

  // Counts each completed access on its entry into RECOVER.
  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_q <= '0;
    end else if ((state == ACCESS) && tc_c) begin
      cyc_q <= cyc_q + CYC_CNT_W'(1);
    end
  end

  assign cycle_cnt = cyc_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_ext_mem_cycle_ctrl.sv
// Self-checking bench for ext_mem_cycle_ctrl: directed cases then random accesses vs a timeline model.
module tb_ext_mem_cycle_ctrl;

  localparam int unsigned ROM_WAIT = 1;
  localparam int unsigned RAM_WAIT = 3;
  localparam int unsigned WE_SETUP = 1;
  localparam int ROM_N = (ROM_WAIT == 0) ? 1 : ROM_WAIT;
  localparam int RAM_N = (RAM_WAIT == 0) ? 1 : RAM_WAIT;
  localparam int SET_N = WE_SETUP;

  // Transaction kinds understood by the model.
  localparam int K_ROM_RD = 0;
  localparam int K_RAM_RD = 1;
  localparam int K_RAM_WR = 2;
  localparam int K_ROM_WR = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        rom_cs, ram_cs, memread, memwrite;
  logic        wait_n, mem_ce_n, mem_oe_n, mem_we_n, rd_latch;
  logic [15:0] cycle_cnt;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] model_cnt = 16'd0;

  always #5 clock = ~clock;

  ext_mem_cycle_ctrl #(
    .ROM_WAIT (ROM_WAIT),
    .RAM_WAIT (RAM_WAIT),
    .WE_SETUP (WE_SETUP),
    .CNT_W    (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rom_cs    (rom_cs),
    .ram_cs    (ram_cs),
    .memread   (memread),
    .memwrite  (memwrite),
    .wait_n    (wait_n),
    .mem_ce_n  (mem_ce_n),
    .mem_oe_n  (mem_oe_n),
    .mem_we_n  (mem_we_n),
    .rd_latch  (rd_latch),
    .cycle_cnt (cycle_cnt)
  );

  function automatic int decode_kind(input logic rc, input logic rr, input logic rd, input logic wr);
    if (rc) return (wr && !rd) ? K_ROM_WR : K_ROM_RD;
    if (rr && wr) return K_RAM_WR;
    return K_RAM_RD;
  endfunction

  // Clocks from the start edge until RECOVER is reached.
  function automatic int txn_len(input int kind);
    case (kind)
      K_ROM_RD: return ROM_N + 1;
      K_RAM_RD: return RAM_N + 1;
      K_RAM_WR: return SET_N + RAM_N + 1;
      default:  return 1;
    endcase
  endfunction

  // Expected {wait_n, ce_n, oe_n, we_n, rd_latch} k clocks after the start edge.
  function automatic logic [4:0] expect_out(input int kind, input int k);
    int n;
    if (kind == K_ROM_WR) return 5'b11110;
    if (kind == K_RAM_WR) begin
      n = SET_N + RAM_N;
      return {(k > n), (k > n + 1), 1'b1, !(k > SET_N && k <= n), 1'b0};
    end
    n = (kind == K_ROM_RD) ? ROM_N : RAM_N;
    return {(k > n), (k > n + 1), (k > n), 1'b1, (k == n + 1)};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic obs, input logic exp, input string where);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @%s: observed %0b expected %0b", name, where, obs, exp);
    end
  endtask

  task automatic check_all(input logic [4:0] e, input logic [15:0] ec, input string where);
    logic [15:0] want;
`ifdef MEM_CYCLE_CNT_EN
    want = ec;
`else
    want = 16'h0000;
`endif
    chk("wait_n",   wait_n,   e[4], where);
    chk("mem_ce_n", mem_ce_n, e[3], where);
    chk("mem_oe_n", mem_oe_n, e[2], where);
    chk("mem_we_n", mem_we_n, e[1], where);
    chk("rd_latch", rd_latch, e[0], where);
    n_cmp++;
    assert (cycle_cnt === want) else begin
      n_fail++;
      $error("FAIL cycle_cnt @%s: observed %0d expected %0d", where, cycle_cnt, want);
    end
  endtask

  // One CPU memory cycle: qualifiers held `hold` clocks, selects optionally dropped at clock sel_drop.
  task automatic run_txn(input logic rc, input logic rr, input logic rd, input logic wr,
                         input int extra, input int sel_drop);
    int kind, len, hold;
    logic [15:0] ec;
    kind = decode_kind(rc, rr, rd, wr);
    len  = txn_len(kind);
    hold = len + 1 + extra;
    rom_cs = rc; ram_cs = rr; memread = rd; memwrite = wr;
    for (int k = 1; k <= hold; k++) begin
      step();
      if (k == sel_drop) begin
        rom_cs = 1'b0;
        ram_cs = 1'b0;
      end
      ec = model_cnt;
      if (kind != K_ROM_WR && k >= len) ec = ec + 16'd1;
      check_all(expect_out(kind, k), ec, $sformatf("kind%0d k%0d", kind, k));
    end
    if (kind != K_ROM_WR) model_cnt = model_cnt + 16'd1;
    rom_cs = 1'b0; ram_cs = 1'b0; memread = 1'b0; memwrite = 1'b0;
    step();
    check_all(5'b11110, model_cnt, $sformatf("kind%0d release", kind));
  endtask

  initial begin
    reset = 1'b1;
    rom_cs = 1'b0; ram_cs = 1'b0; memread = 1'b0; memwrite = 1'b0;
    step();
    step();
    check_all(5'b11110, 16'd0, "por");
    reset = 1'b0;
    step();
    check_all(5'b11110, 16'd0, "idle");

    // ROM read held 6 clocks, then back-to-back RAM read
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, 3, 0);
    run_txn(1'b0, 1'b1, 1'b1, 1'b0, 2, 0);
    // RAM write, ROM write, write with select dropped during ACCESS
    run_txn(1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
    run_txn(1'b1, 1'b0, 1'b0, 1'b1, 2, 0);
    run_txn(1'b0, 1'b1, 1'b0, 1'b1, 1, 3);
    // Illegal combinations: both selects, both qualifiers
    run_txn(1'b1, 1'b1, 1'b0, 1'b1, 0, 0);
    run_txn(1'b0, 1'b1, 1'b1, 1'b1, 0, 0);
    run_txn(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);

    // Reset held 3 clocks while a RAM read is in ACCESS
    rom_cs = 1'b0; ram_cs = 1'b1; memread = 1'b1; memwrite = 1'b0;
    step();
    step();
    check_all(expect_out(K_RAM_RD, 2), model_cnt, "pre_reset");
    reset = 1'b1;
    ram_cs = 1'b0; memread = 1'b0;
    model_cnt = 16'd0;
    for (int r = 0; r < 3; r++) begin
      step();
      check_all(5'b11110, 16'd0, $sformatf("mid_reset%0d", r));
    end
    reset = 1'b0;
    step();
    check_all(5'b11110, 16'd0, "post_reset");

    for (int t = 0; t < 30; t++) begin
      logic rc, rr, rd, wr;
      do begin
        rc = 1'($urandom_range(0, 1));
        rr = 1'($urandom_range(0, 1));
        rd = 1'($urandom_range(0, 1));
        wr = 1'($urandom_range(0, 1));
      end while (!((rc | rr) && (rd | wr)));
      run_txn(rc, rr, rd, wr, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
